// File: rtl/seg7_frame_reader.sv
// Multiplexed 7-segment bus readback: filters each strobed digit for stability,
// decodes it to BCD / blank / error and hands complete frames off over valid/ready.
module seg7_frame_reader #(
  parameter int unsigned NDIG   = 4,
  parameter int unsigned STABLE = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [6:0]        seg,
  input  logic [NDIG-1:0]   digit_sel,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [4*NDIG-1:0] bcd_out,
  output logic [NDIG-1:0]   blank_out,
  output logic [NDIG-1:0]   err_out,
  output logic              overrun
);

  localparam int unsigned CW      = 4;
  localparam int unsigned BW      = 4 * NDIG;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE);
  localparam logic [CW-1:0] CNT_CAP = CW'(STABLE - 1);
  localparam logic [NDIG-1:0] ALL_ONES = {NDIG{1'b1}};

  // Sample history and stability tracking
  logic [NDIG-1:0] prev_sel;
  logic [6:0]      prev_seg;
  logic [CW-1:0]   cnt;
  logic            armed;

  // Frame assembly
  logic [NDIG-1:0] mask;
  logic [BW-1:0]   asm_bcd;
  logic [NDIG-1:0] asm_blank;
  logic [NDIG-1:0] asm_err;
  logic            done;

  // Combinational helpers
  logic            sel_onehot;
  logic            same;
  logic            restart;
  logic [CW-1:0]   cnt_nxt;
  logic            capture;
  logic            armed_nxt;
  logic [NDIG-1:0] mask_set;
  logic            frame_full;
  logic [NDIG-1:0] mask_nxt;
  logic [3:0]      dec_nib;
  logic            dec_blank;
  logic            dec_err;
  logic            load;
  logic            drop;
  logic            accept;

  // Segment pattern to BCD / blank / error decode
  always_comb begin
    dec_nib   = 4'hF;
    dec_blank = 1'b0;
    dec_err   = 1'b0;
    case (seg)
      7'h3F: dec_nib = 4'd0;
      7'h06: dec_nib = 4'd1;
      7'h5B: dec_nib = 4'd2;
      7'h4F: dec_nib = 4'd3;
      7'h66: dec_nib = 4'd4;
      7'h6D: dec_nib = 4'd5;
      7'h7D: dec_nib = 4'd6;
      7'h07: dec_nib = 4'd7;
      7'h7F: dec_nib = 4'd8;
      7'h6F: dec_nib = 4'd9;
      7'h00: begin
        dec_nib   = 4'h0;
        dec_blank = 1'b1;
      end
      default: begin
        dec_nib = 4'hF;
        dec_err = 1'b1;
      end
    endcase
  end

  // Stability counter update and capture qualification
  always_comb begin
    sel_onehot = $onehot(digit_sel);
    same       = (digit_sel == prev_sel) && (seg == prev_seg);
    restart    = 1'b1;
    cnt_nxt    = '0;
    if (sel_onehot && same) begin
      restart = 1'b0;
      if (cnt == CNT_MAX) begin
        cnt_nxt = cnt;
      end else begin
        cnt_nxt = cnt + CW'(1);
      end
    end
    // A restart re-arms in the same cycle, so a single-sample filter captures at once
    capture = sel_onehot && (cnt_nxt == CNT_CAP) && (armed || restart);
    if (capture) begin
      armed_nxt = 1'b0;
    end else if (restart) begin
      armed_nxt = 1'b1;
    end else begin
      armed_nxt = armed;
    end
  end

  // Capture mask bookkeeping; a full frame clears the mask so the next one starts fresh
  always_comb begin
    mask_set   = capture ? (mask | digit_sel) : mask;
    frame_full = (mask_set == ALL_ONES);
    mask_nxt   = frame_full ? '0 : mask_set;
  end

  // Output-side decisions for a frame that completed last cycle
  always_comb begin
    accept = out_valid && out_ready;
    load   = done && (!out_valid || out_ready);
    drop   = done && out_valid && !out_ready;
  end

  // Sample history and stability state
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_sel <= '0;
      prev_seg <= '0;
      cnt      <= '0;
      armed    <= 1'b1;
    end else begin
      prev_sel <= digit_sel;
      prev_seg <= seg;
      cnt      <= cnt_nxt;
      armed    <= armed_nxt;
    end
  end

  // Assembly slots, mask and frame-complete flag
  always_ff @(posedge clk) begin
    if (rst) begin
      mask      <= '0;
      asm_bcd   <= '0;
      asm_blank <= '0;
      asm_err   <= '0;
      done      <= 1'b0;
    end else begin
      mask <= mask_nxt;
      done <= frame_full;
      for (int i = 0; i < int'(NDIG); i++) begin
        if (capture && digit_sel[i]) begin
          asm_bcd[4*i +: 4] <= dec_nib;
          asm_blank[i]      <= dec_blank;
          asm_err[i]        <= dec_err;
        end
      end
    end
  end

  // Output registers, handshake and sticky overrun
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      bcd_out   <= '0;
      blank_out <= '0;
      err_out   <= '0;
      overrun   <= 1'b0;
    end else begin
      if (load) begin
        out_valid <= 1'b1;
        bcd_out   <= asm_bcd;
        blank_out <= asm_blank;
        err_out   <= asm_err;
      end else if (accept) begin
        out_valid <= 1'b0;
      end
      if (drop) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule
